serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the combinational full-adder datapath. Used where area matters more than latency.
- Start/busy/done handshake so a controller FSM can issue operations and collect results.

Parameters:
WIDTH  8  operand and result width in bits; legal range 2..32

Ports:
clk         input   1      system clock, all state updates on rising edge
rst_n       input   1      asynchronous active-low reset
start       input   1      request a new operation; sampled only when busy=0
a           input   WIDTH  minuend; captured on accepted start
b           input   WIDTH  subtrahend; captured on accepted start
busy        output  1      high while the subtraction is in progress
done        output  1      one-cycle pulse when results become valid
diff        output  WIDTH  result a - b modulo 2^WIDTH
borrow_out  output  1      unsigned borrow: 1 iff a < b (unsigned)
overflow    output  1      signed overflow of a - b

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, any state):
  - state goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0, overflow=0.
  - Operand/result shift registers, borrow FF and counter all cleared.
  - Release is synchronous to clk.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - busy=0.
  - start=1 at an edge: latch a into A_sr and b into B_sr, latch a[WIDTH-1] and b[WIDTH-1] as sign bits, clear borrow FF, count=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), one bit per edge:
  - Cell inputs: x = A_sr[0], y = B_sr[0], bin = borrow FF.
  - d = x ^ y ^ bin.
  - bout = (~x & y) | (~(x ^ y) & bin).
  - R_sr shifts right with d inserted at MSB. A_sr and B_sr shift right. borrow FF <= bout. count increments.
  - When count reaches WIDTH-1 at an edge (i.e. the WIDTH-th bit is processed), go to DONE.
  - start is ignored in SHIFT. a and b may change freely without effect.
- On the transition SHIFT->DONE, registered outputs update on the same edge:
  - diff <= final R_sr.
  - borrow_out <= final bout.
  - overflow <= (sign_a != sign_b) && (final d != sign_a).
- DONE:
  - done=1, busy=0. done lasts exactly one cycle.
  - start=1: accepted exactly as in IDLE (back-to-back operation), next state SHIFT.
  - start=0: next state IDLE.
- Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Result hold: diff, borrow_out and overflow hold their values from the DONE edge until the next operation completes or reset. They do not change during a subsequent SHIFT.
- Boundaries:
  - Equal operands give diff=0, borrow_out=0, overflow=0.
  - a=0, b=1 wraps to all ones with borrow_out=1.
  - Most-negative minus positive sets overflow.
- Reset asserted mid-SHIFT aborts the operation. No done pulse is issued and all outputs go to reset values.
- No X propagation: all outputs are driven from registers, never combinationally from inputs.

Test Plan:
1. WIDTH=8, start with a=8'd5, b=8'd3 -> busy=1 for 8 cycles; done pulses once in the 9th cycle after acceptance; diff=8'h02, borrow_out=0, overflow=0.
2. a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1, overflow=0. Then a=8'h80, b=8'h01 -> diff=8'h7F, borrow_out=0, overflow=1.
3. a=b=8'hA5 -> diff=0, borrow_out=0, overflow=0. Then a=0, b=8'h01 -> diff=8'hFF, borrow_out=1, overflow=0.
4. Start a=8'h10, b=8'h01; pulse start with a=8'hFF, b=8'hFF during cycle 3 of SHIFT -> second start ignored; only one done; diff=8'h0F.
5. Start a=8'h20, b=8'h02 and hold start=1 with a=8'h07, b=8'h09 in the done cycle -> second op accepted back-to-back; first result diff=8'h1E holds through the second SHIFT; second done gives diff=8'hFE, borrow_out=1.
6. Drop rst_n mid-SHIFT (cycle 4), asynchronously between edges -> busy, done, diff, borrow_out and overflow go to 0 immediately; no done after release; a fresh start 8'h09-8'h04 then yields diff=8'h05.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
// start/busy/done handshake; results hold until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             brw, sign_a, sign_b;
  logic             x, y, d, bout;
  logic             accept, last;

  // Full-subtractor cell on the current LSBs
  assign x      = a_sr[0];
  assign y      = b_sr[0];
  assign d      = x ^ y ^ brw;
  assign bout   = (~x & y) | (~(x ^ y) & brw);

  // start is only honoured outside SHIFT (DONE accepts back-to-back)
  assign accept = start && (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
    end
  end

  // Operand load, serial datapath and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sign_a <= a[WIDTH-1];
      sign_b <= b[WIDTH-1];
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {d, r_sr[WIDTH-1:1]};
      brw  <= bout;
      cnt  <= cnt + 1'b1;
      if (last) begin
        // The final d is the result sign; overflow only when operand signs differ
        diff       <= {d, r_sr[WIDTH-1:1]};
        borrow_out <= bout;
        overflow   <= (sign_a != sign_b) && (d != sign_a);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow_out, overflow;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int sx, sy, sd;
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy;
    d  = W'(int'(x) - int'(y));
    bo = (x < y);
    ov = (sd > (2**(W-1) - 1)) || (sd < -(2**(W-1)));
  endtask

  // Called just before the accepting edge; leaves inputs scrambled after it
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb);
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
  endtask

  // Walk the SHIFT phase, optionally pulsing start at SHIFT cycle 3,
  // then check the done cycle; returns at the done-cycle negedge.
  task automatic wait_res(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input bit intr);
    logic [W-1:0] ed;
    logic eb, eo;
    model(ta, tb, ed, eb, eo);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({tag, "/busy"}, busy, 1);
      chk({tag, "/nodone"}, done, 0);
      chk({tag, "/hold"}, diff, prev_diff);
      if (intr && i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (intr && i == 3) start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "/done"}, done, 1);
    chk({tag, "/busy0"}, busy, 0);
    chk({tag, "/diff"}, diff, ed);
    chk({tag, "/borrow"}, borrow_out, eb);
    chk({tag, "/ovf"}, overflow, eo);
    prev_diff = ed;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit intr);
    @(negedge clk);
    issue(ta, tb);
    wait_res(tag, ta, tb, intr);
    @(negedge clk);
    chk({tag, "/pulse"}, done, 0);
    chk({tag, "/idle"}, busy, 0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/diff", diff, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle/busy", busy, 0);
    chk("idle/flags", {borrow_out, overflow}, 0);

    // Directed cases
    do_op("t1", 8'd5, 8'd3, 0);
    do_op("t2a", 8'd3, 8'd5, 0);
    do_op("t2b", 8'h80, 8'h01, 0);
    do_op("t3a", 8'hA5, 8'hA5, 0);
    do_op("t3b", 8'h00, 8'h01, 0);
    do_op("t4", 8'h10, 8'h01, 1);
    @(negedge clk);
    chk("t4/single", done, 0);

    // Back-to-back: second start presented in the done cycle
    @(negedge clk);
    issue(8'h20, 8'h02);
    wait_res("t5a", 8'h20, 8'h02, 0);
    issue(8'h07, 8'h09);
    wait_res("t5b", 8'h07, 8'h09, 0);
    @(negedge clk);
    chk("t5/pulse", done, 0);

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    issue(8'h55, 8'h11);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6/busy", busy, 0);
    chk("t6/done", done, 0);
    chk("t6/diff", diff, 0);
    chk("t6/flags", {borrow_out, overflow}, 0);
    prev_diff = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("t6/nodone", done, 0);
    end
    do_op("t6b", 8'h09, 8'h04, 0);

    // Randomized operations, some back-to-back
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 5 == 0) rb = ra;
      if (n % 4 == 3) begin
        logic [W-1:0] ra2, rb2;
        ra2 = W'($urandom);
        rb2 = W'($urandom);
        @(negedge clk);
        issue(ra, rb);
        wait_res("rnd_b2b1", ra, rb, 0);
        issue(ra2, rb2);
        wait_res("rnd_b2b2", ra2, rb2, 0);
        @(negedge clk);
        chk("rnd_b2b/pulse", done, 0);
      end else begin
        do_op("rnd", ra, rb, bit'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
